uart_mmio: RTL and testbench
============================

UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 Parameter BASE_ADDR, default 32'h10010000, word-aligned base of the 16-byte register window.
REQ-002 Parameter TX_DEPTH, default 8, TX FIFO entries (power of two, >=2).
REQ-003 Parameter RX_DEPTH, default 8, RX FIFO entries (power of two, >=2).
REQ-004 Parameter DEFAULT_DIV, default 16'd434, reset value of clocks-per-bit divisor.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 address  input  32  byte address from core.
REQ-008 write_data  input  32  store data.
REQ-009 write_mask  input  4  byte enables; a register is written only if write_mask[0]=1.
REQ-010 write_enable  input  1  store strobe, one access per cycle.
REQ-011 read_enable  input  1  load strobe; qualifies read side effects.
REQ-012 read_data  output  32  combinational read of addressed register; 0 when not hit.
REQ-013 rx  input  1  serial input, asynchronous to clk.
REQ-014 tx  output  1  serial output, idle high.
REQ-015 irq  output  1  level interrupt = (rx_valid & ctrl.rx_ie) | any sticky error.

Function
REQ-016 Hit SHALL be address[31:4]==BASE_ADDR[31:4]; offset = address[3:2].
REQ-017 Offset 0 DATA: write pushes write_data[7:0] to TX FIFO; read returns {24'b0, RX head}, and pops on read_enable; read of empty RX returns 0, no pop.
REQ-018 Offset 1 STATUS (read-only): b0 rx_valid, b1 rx_full, b2 tx_full, b3 tx_empty, b4 tx_busy, b5 rx_overrun, b6 frame_error, b7 tx_overflow; others 0.
REQ-019 Offset 2 DIVISOR: [15:0] clocks per bit; writes with value <4 ignored.
REQ-020 Offset 3 CTRL: b0 loopback, b1 rx_ie (read/write); b8 write-1 clears b5-b7; b9 write-1 flushes both FIFOs; b8/b9 read 0.
REQ-021 Write to DATA when TX full SHALL drop byte and set tx_overflow.
REQ-022 TX FSM states IDLE, START, DATA, STOP; IDLE pops FIFO when non-empty, latches byte and DIVISOR.
REQ-023 tx SHALL go low the cycle after the push edge when TX FIFO was empty and FSM IDLE (latency 1 cycle).
REQ-024 Each bit SHALL last exactly latched-DIVISOR cycles: start 0, 8 data LSB first, stop 1; next frame may start immediately after stop.
REQ-025 DIVISOR change SHALL affect only frames started afterwards (TX and RX).
REQ-026 tx_busy = FSM not IDLE.
REQ-027 RX input SHALL pass a 2-flop synchronizer; in loopback the RX FSM samples tx instead (tx pin still driven).
REQ-028 RX FSM states IDLE, START, DATA, STOP; IDLE detects high-to-low on synchronized input.
REQ-029 START samples at DIVISOR/2 (floor); if high, return IDLE (glitch, no error).
REQ-030 Data bits sampled every DIVISOR cycles after start-centre; stop bit sampled likewise.
REQ-031 Stop sample 0 SHALL set frame_error and discard byte.
REQ-032 Valid byte with RX FIFO full SHALL set rx_overrun and discard byte, unless a pop occurs the same cycle, in which case push is accepted.
REQ-033 Simultaneous push and pop on either FIFO SHALL keep count unchanged and preserve order.
REQ-034 Flush (b9) SHALL empty FIFOs in one cycle, not abort a frame in progress.
REQ-035 Pointers SHALL wrap modulo depth; count width clog2(depth)+1.

Reset
REQ-036 On rst=0: tx=1, both FSMs IDLE, FIFOs empty, DIVISOR=DEFAULT_DIV, CTRL=0, sticky bits 0, irq=0; read_data reflects reset state.
REQ-037 Reset mid-frame SHALL abort immediately; tx=1 while asserted and after release until next push.
REQ-038 Release SHALL be synchronous to clk internally; first push accepted on first edge after release.

Verification
REQ-039 DIVISOR=4, write 0xA5 to DATA -> tx low at cycle+1, bits 1,0,1,0,0,1,0,1, stop high; frame 40 cycles.
REQ-040 Loopback, DIVISOR=8, write 0x3C -> after ~80 cycles STATUS b0=1, DATA read = 0x3C, STATUS b0=0 after pop.
REQ-041 Write 9 bytes with TX_DEPTH=8 while busy -> ninth dropped, STATUS b7=1; CTRL write 0x100 clears it.
REQ-042 Drive rx frame 0x55 with stop bit 0 -> STATUS b6=1, irq=1, RX FIFO empty.
REQ-043 Fill RX (8 frames), send 9th without reading -> b5=1, FIFO holds first 8 in order.
REQ-044 Assert rst=0 mid-TX frame -> tx=1 within same cycle, STATUS=0x08, DIVISOR=434.

Source files
------------

// File: rtl/uart_mmio.sv
// Memory-mapped UART: 4-register window (DATA, STATUS, DIVISOR, CTRL), TX/RX FIFOs,
// 8N1 framing with a runtime clocks-per-bit divisor, optional internal loopback.
module uart_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned RX_DEPTH    = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] read_data,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned TxCw = TxAw + 1;
  localparam int unsigned RxAw = $clog2(RX_DEPTH);
  localparam int unsigned RxCw = RxAw + 1;

  // Shared encoding for both serial FSMs
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       hit;
  logic [1:0] offset;
  logic       wr_en;
  logic       wr_data, wr_div, wr_ctrl, rd_data_pop;
  logic       flush, clr_sticky;

  assign hit         = (address[31:4] == BASE_ADDR[31:4]);
  assign offset      = address[3:2];
  assign wr_en       = hit & write_enable & write_mask[0];
  assign wr_data     = wr_en & (offset == 2'd0);
  assign wr_div      = wr_en & (offset == 2'd2);
  assign wr_ctrl     = wr_en & (offset == 2'd3);
  assign flush       = wr_ctrl & write_data[9];
  assign clr_sticky  = wr_ctrl & write_data[8];
  assign rd_data_pop = hit & read_enable & (offset == 2'd0);

  logic unused_bits;
  assign unused_bits = ^{address[1:0], write_mask[3:1], write_data[31:16]};

  // ---------------------------------------------------------------------------
  // Control / status registers
  // ---------------------------------------------------------------------------
  logic [15:0] divisor;
  logic        loopback, rx_ie;
  logic        rx_overrun, frame_error, tx_overflow;
  logic        overrun_set, frame_set;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      tx_mem [TX_DEPTH];
  logic [TxAw-1:0] tx_wptr, tx_rptr;
  logic [TxCw-1:0] tx_count;
  logic            tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]      tx_head;

  assign tx_full  = (tx_count == TxCw'(TX_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign tx_push  = wr_data & ~tx_full;
  assign tx_head  = tx_mem[tx_rptr];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= write_data[7:0];
  end

  // Pointers and occupancy; flush wins over any concurrent push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else if (flush) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (tx_push & ~tx_pop)      tx_count <= tx_count + 1'b1;
      else if (~tx_push & tx_pop) tx_count <= tx_count - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // TX serializer
  // ---------------------------------------------------------------------------
  logic [1:0]  tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;
  logic        tx_q;
  logic        tx_bit_end;

  assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
  // Pop when idle, or back-to-back at the last cycle of a stop bit
  assign tx_pop     = ~tx_empty & ((tx_state == StIdle) | ((tx_state == StStop) & tx_bit_end));
  assign tx         = tx_q;

  // Frame sequencing; divisor and byte are latched when a frame starts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= StIdle;
      tx_cnt   <= '0;
      tx_div   <= DEFAULT_DIV;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (tx_state)
        StIdle: begin
          if (tx_pop) begin
            tx_state <= StStart;
            tx_shift <= tx_head;
            tx_div   <= divisor;
            tx_cnt   <= '0;
            tx_q     <= 1'b0;
          end
        end
        StStart: begin
          if (tx_bit_end) begin
            tx_state <= StData;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_q     <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        StData: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= StStop;
              tx_q     <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_q     <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: begin  // StStop
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_state <= StStart;
              tx_shift <= tx_head;
              tx_div   <= divisor;
              tx_q     <= 1'b0;
            end else begin
              tx_state <= StIdle;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX synchronizer and deserializer
  // ---------------------------------------------------------------------------
  logic        rx_meta, rx_sync, rx_prev, rx_in;
  logic [1:0]  rx_state;
  logic [15:0] rx_cnt, rx_div;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;
  logic        rx_bit_end, rx_half, rx_stop_smp, rx_push_req;

  // Loopback taps the internal serializer; the tx pin keeps being driven
  assign rx_in       = loopback ? tx_q : rx_sync;
  assign rx_bit_end  = (rx_cnt == rx_div - 16'd1);
  assign rx_half     = (rx_cnt == (rx_div >> 1) - 16'd1);
  assign rx_stop_smp = (rx_state == StStop) & rx_bit_end;
  assign rx_push_req = rx_stop_smp & rx_in;
  assign frame_set   = rx_stop_smp & ~rx_in;

  // Two-flop synchronizer plus previous-sample register for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_in;
    end
  end

  // Frame sampling: start verified at half a bit, then one sample per bit period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= StIdle;
      rx_cnt   <= '0;
      rx_div   <= DEFAULT_DIV;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        StIdle: begin
          if (rx_prev & ~rx_in) begin
            rx_state <= StStart;
            rx_cnt   <= '0;
            rx_div   <= divisor;
          end
        end
        StStart: begin
          if (rx_half) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_in ? StIdle : StData;  // high at centre: glitch
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        StData: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_in, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= StStop;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: begin  // StStop
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_state <= StIdle;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      rx_mem [RX_DEPTH];
  logic [RxAw-1:0] rx_wptr, rx_rptr;
  logic [RxCw-1:0] rx_count;
  logic            rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]      rx_head;

  assign rx_full     = (rx_count == RxCw'(RX_DEPTH));
  assign rx_empty    = (rx_count == '0);
  assign rx_pop      = rd_data_pop & ~rx_empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the byte
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);
  assign overrun_set = rx_push_req & rx_full & ~rx_pop;
  assign rx_head     = rx_empty ? 8'h00 : rx_mem[rx_rptr];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_shift;
  end

  // Pointers and occupancy; flush wins over any concurrent push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else if (flush) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      if (rx_push & ~rx_pop)      rx_count <= rx_count + 1'b1;
      else if (~rx_push & rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Register updates; a sticky set in the same cycle as a clear wins
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor     <= DEFAULT_DIV;
      loopback    <= 1'b0;
      rx_ie       <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_error <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (wr_div && (write_data[15:0] >= 16'd4)) divisor <= write_data[15:0];
      if (wr_ctrl) begin
        loopback <= write_data[0];
        rx_ie    <= write_data[1];
      end
      rx_overrun  <= (rx_overrun  & ~clr_sticky) | overrun_set;
      frame_error <= (frame_error & ~clr_sticky) | frame_set;
      tx_overflow <= (tx_overflow & ~clr_sticky) | (wr_data & tx_full);
    end
  end

  // Combinational read mux
  always_comb begin
    read_data = 32'h0;
    if (hit) begin
      case (offset)
        2'd0:    read_data = {24'h0, rx_head};
        2'd1:    read_data = {24'h0, tx_overflow, frame_error, rx_overrun,
                              (tx_state != StIdle), tx_empty, tx_full, rx_full, ~rx_empty};
        2'd2:    read_data = {16'h0, divisor};
        default: read_data = {30'h0, rx_ie, loopback};
      endcase
    end
  end

  assign irq = (~rx_empty & rx_ie) | rx_overrun | frame_error | tx_overflow;

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: register table plus hand-written serial sequences.
module tb_uart_mmio;

  localparam logic [31:0] BASE   = 32'h10010000;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_DIV  = BASE + 32'h8;
  localparam logic [31:0] A_CTRL = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, write_data;
  logic [3:0]  write_mask;
  logic        write_enable, read_enable, rx;
  logic [31:0] read_data;
  logic        tx, irq;

  int n_tests = 0;
  int n_fail  = 0;

  uart_mmio dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .write_data   (write_data),
    .write_mask   (write_mask),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .rx           (rx),
    .tx           (tx),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change just after a negedge; the following posedge takes them
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    address = a; write_data = d; write_mask = m; write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] v);
    address = a;
    #1 v = read_data;
  endtask

  task automatic rd_pop(input logic [31:0] a, output logic [31:0] v);
    address = a; read_enable = 1'b1;
    #1 v = read_data;
    @(negedge clk);
    read_enable = 1'b0;
  endtask

  // Drive one 8N1 frame on rx at 8 clocks per bit
  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (8) @(negedge clk);
    end
    rx = stop;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_tx_idle(input string name);
    logic [31:0] s;
    logic        done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      peek(A_STAT, s);
      if (!s[4]) done = 1'b1;
    end
    chk(name, {31'h0, done}, 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic        txh [42];
    logic        bsy [42];
    logic [7:0]  rxb [8];
    logic        exp_bits [10];
    logic        seen;

    vecs[0]  = '{1'b0, A_STAT, 32'h0,        4'hF, A_STAT,        32'h08};
    vecs[1]  = '{1'b0, A_DIV,  32'h0,        4'hF, A_DIV,         32'h1B2};
    vecs[2]  = '{1'b0, A_CTRL, 32'h0,        4'hF, A_CTRL,        32'h0};
    vecs[3]  = '{1'b0, A_DATA, 32'h0,        4'hF, A_DATA,        32'h0};
    vecs[4]  = '{1'b0, A_DATA, 32'h0,        4'hF, BASE + 32'h14, 32'h0};
    vecs[5]  = '{1'b1, A_DIV,  32'h3,        4'hF, A_DIV,         32'h1B2};
    vecs[6]  = '{1'b1, A_DIV,  32'h10,       4'hE, A_DIV,         32'h1B2};
    vecs[7]  = '{1'b1, A_DIV,  32'hFFFF0004, 4'hF, A_DIV,         32'h4};
    vecs[8]  = '{1'b1, A_STAT, 32'hFF,       4'hF, A_STAT,        32'h08};
    vecs[9]  = '{1'b1, A_CTRL, 32'h302,      4'hF, A_CTRL,        32'h2};
    vecs[10] = '{1'b1, A_CTRL, 32'h1,        4'h1, A_CTRL,        32'h1};
    vecs[11] = '{1'b1, A_CTRL, 32'h0,        4'hF, A_CTRL,        32'h0};

    // 0xA5 LSB first, framed by start 0 and stop 1
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rxb      = '{8'h00, 8'hFF, 8'h81, 8'h42, 8'h24, 8'h18, 8'h7E, 8'hA5};

    rst = 1'b0; rx = 1'b1; address = '0; write_data = '0; write_mask = '0;
    write_enable = 1'b0; read_enable = 1'b0;
    repeat (3) @(negedge clk);
    peek(A_STAT, v);
    chk("reset_status", v, 32'h08);
    chk("reset_tx", {31'h0, tx}, 32'h1);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Register table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata, vecs[i].wmask);
      peek(vecs[i].raddr, v);
      chk($sformatf("vec%0d", i), v, vecs[i].exp);
    end
    chk("irq_idle", {31'h0, irq}, 32'h0);

    // TX frame 0xA5 at divisor 4: sample 0 is the negedge right after the push edge
    wr(A_DATA, 32'hA5, 4'hF);
    peek(A_STAT, v);
    txh[0] = tx; bsy[0] = v[4];
    for (int i = 1; i < 42; i++) begin
      @(negedge clk);
      peek(A_STAT, v);
      txh[i] = tx; bsy[i] = v[4];
    end
    chk("tx_before_start", {31'h0, txh[0]}, 32'h1);
    chk("tx_start_first", {31'h0, txh[1]}, 32'h0);
    chk("tx_start_last", {31'h0, txh[4]}, 32'h0);
    chk("tx_bit0_first", {31'h0, txh[5]}, 32'h1);
    for (int k = 0; k < 10; k++)
      chk($sformatf("tx_bit%0d", k), {31'h0, txh[2 + 4 * k]}, {31'h0, exp_bits[k]});
    chk("tx_busy_end_stop", {31'h0, bsy[40]}, 32'h1);
    chk("tx_idle_after", {31'h0, bsy[41]}, 32'h0);
    chk("tx_line_after", {31'h0, txh[41]}, 32'h1);

    // TX overflow: one byte in flight, then 8 fill the FIFO and a 9th is dropped
    wr(A_DATA, 32'h01, 4'hF);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) wr(A_DATA, 32'h80 + i, 4'hF);
    peek(A_STAT, v);
    chk("tx_full", v, 32'h14);
    wr(A_DATA, 32'hEE, 4'hF);
    peek(A_STAT, v);
    chk("tx_overflow", v, 32'h94);
    chk("irq_overflow", {31'h0, irq}, 32'h1);
    wr(A_CTRL, 32'h100, 4'hF);
    peek(A_STAT, v);
    chk("overflow_clear", v, 32'h14);
    wr(A_CTRL, 32'h200, 4'hF);
    peek(A_STAT, v);
    chk("flush_keeps_frame", v, 32'h18);
    wait_tx_idle("flush_drain");

    // Loopback at divisor 8
    wr(A_CTRL, 32'h3, 4'hF);
    wr(A_DIV, 32'h8, 4'hF);
    wr(A_DATA, 32'h3C, 4'hF);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      peek(A_STAT, v);
      if (v[0]) seen = 1'b1;
    end
    chk("loop_rx_valid", {31'h0, seen}, 32'h1);
    chk("loop_irq", {31'h0, irq}, 32'h1);
    rd_pop(A_DATA, v);
    chk("loop_data", v, 32'h3C);
    peek(A_STAT, v);
    chk("loop_popped", v & 32'h1, 32'h0);
    chk("loop_irq_off", {31'h0, irq}, 32'h0);
    wait_tx_idle("loop_tx_done");
    wr(A_CTRL, 32'h0, 4'hF);

    // Frame error on bad stop bit
    send_rx(8'h55, 1'b0);
    peek(A_STAT, v);
    chk("frame_error", v, 32'h48);
    chk("irq_frame", {31'h0, irq}, 32'h1);
    wr(A_CTRL, 32'h100, 4'hF);
    peek(A_STAT, v);
    chk("frame_clear", v, 32'h08);

    // Short low glitch is rejected at the start-bit centre
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    peek(A_STAT, v);
    chk("glitch_ignored", v, 32'h08);

    // Fill RX FIFO, then overrun with a ninth frame
    for (int i = 0; i < 8; i++) send_rx(rxb[i], 1'b1);
    peek(A_STAT, v);
    chk("rx_full", v, 32'h0B);
    send_rx(8'hEE, 1'b1);
    peek(A_STAT, v);
    chk("rx_overrun", v, 32'h2B);
    chk("irq_overrun", {31'h0, irq}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      rd_pop(A_DATA, v);
      chk($sformatf("rx_order%0d", i), v, {24'h0, rxb[i]});
    end
    peek(A_STAT, v);
    chk("rx_drained", v, 32'h28);
    rd_pop(A_DATA, v);
    chk("rx_empty_read", v, 32'h0);
    wr(A_CTRL, 32'h100, 4'hF);

    // Reset in the middle of a start bit
    wr(A_DATA, 32'h5A, 4'hF);
    repeat (2) @(negedge clk);
    #1 chk("pre_reset_tx_low", {31'h0, tx}, 32'h0);
    rst = 1'b0;
    #1 chk("reset_tx_high", {31'h0, tx}, 32'h1);
    peek(A_STAT, v);
    chk("reset_mid_status", v, 32'h08);
    peek(A_DIV, v);
    chk("reset_mid_div", v, 32'h1B2);
    chk("reset_mid_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wr(A_DATA, 32'h33, 4'hF);
    peek(A_STAT, v);
    chk("first_push_after_reset", v, 32'h00);
    chk("tx_high_until_start", {31'h0, tx}, 32'h1);
    @(negedge clk);
    #1 chk("tx_start_after_reset", {31'h0, tx}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
